// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad one column at a time and locks onto a
//   single pressed key. No debouncing is done here; the downstream debouncer
//   filters any pressed toggles caused by bounce straddling a scan tick.
//
// Ports
//   clk      system clock
//   reset    synchronous, active-high reset
//   counter  free-running counter shared with the debouncer (read only)
//   rows     raw keypad rows, active-low, asynchronous to clk
//   cols     column drive, active-low, exactly one bit low
//   pressed  high while a key is locked
//   key      hex code of the locked key, held after release
module keypad_scanner #(
  parameter int unsigned SCAN_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] counter,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic        pressed,
  output logic [3:0]  key
);

  typedef enum logic {
    SCAN = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  sync1_q, rows_s_q;
  logic        bit_q;
  logic        tick;
  logic [1:0]  col_q, col_d;
  logic [3:0]  cols_q;
  logic [1:0]  hrow_q, hrow_d;
  logic [3:0]  key_q, key_d;
  logic        pressed_q, pressed_d;
  logic        hit;
  logic [1:0]  hit_row;
  logic        unused_counter_bits;

  // Only one counter bit is meaningful here; fold the rest so the full
  // shared bus can be connected without unused-bit noise.
  assign unused_counter_bits = ^counter;

  assign tick = counter[SCAN_BIT] & ~bit_q;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = '0;
    case ({r, c})
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h2;
      4'd2:  code = 4'h3;
      4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h6;
      4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;
      4'd9:  code = 4'h8;
      4'd10: code = 4'h9;
      4'd11: code = 4'hC;
      4'd12: code = 4'hE;
      4'd13: code = 4'h0;
      4'd14: code = 4'hF;
      4'd15: code = 4'hD;
      default: code = '0;
    endcase
    return code;
  endfunction

  // A lock needs exactly one low row; idle and multi-key patterns both miss.
  always_comb begin
    hit     = 1'b0;
    hit_row = '0;
    case (rows_s_q)
      4'b1110: begin hit = 1'b1; hit_row = 2'd0; end
      4'b1101: begin hit = 1'b1; hit_row = 2'd1; end
      4'b1011: begin hit = 1'b1; hit_row = 2'd2; end
      4'b0111: begin hit = 1'b1; hit_row = 2'd3; end
      default: begin hit = 1'b0; hit_row = '0; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    hrow_d    = hrow_q;
    key_d     = key_q;
    pressed_d = pressed_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (hit) begin
            hrow_d    = hit_row;
            key_d     = key_map(hit_row, col_q);
            pressed_d = 1'b1;
            state_d   = HOLD;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        HOLD: begin
          // Only the latched row matters; other rows are ignored while held.
          if (rows_s_q[hrow_q]) begin
            pressed_d = 1'b0;
            col_d     = col_q + 2'd1;
            state_d   = SCAN;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= '1;
      rows_s_q  <= '1;
      bit_q     <= 1'b0;
      state_q   <= SCAN;
      col_q     <= '0;
      cols_q    <= 4'b1110;
      hrow_q    <= '0;
      key_q     <= '0;
      pressed_q <= 1'b0;
    end else begin
      sync1_q   <= rows;
      rows_s_q  <= sync1_q;
      bit_q     <= counter[SCAN_BIT];
      state_q   <= state_d;
      col_q     <= col_d;
      // Column drive decoded from the next index so cols comes straight off flops.
      cols_q    <= ~(4'b0001 << col_d);
      hrow_q    <= hrow_d;
      key_q     <= key_d;
      pressed_q <= pressed_d;
    end
  end

  assign cols    = cols_q;
  assign pressed = pressed_q;
  assign key     = key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] counter = '0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        pressed;
  logic [3:0]  key;

  // Physical keypad model: bit r*4+c set means the key at row r, column c is down.
  logic [15:0] keys_down = '0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  cols;
    logic        pressed;
    logic [3:0]  key;
    string       name;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  logic [3:0] legend [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  always #5 clk = ~clk;

  always @(posedge clk) counter <= counter + 32'd1;

  always_comb begin
    rows = '1;
    for (int r = 0; r < 4; r++)
      rows[r] = ~|(keys_down[r*4 +: 4] & ~cols);
  end

  keypad_scanner #(.SCAN_BIT(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .counter (counter),
    .rows    (rows),
    .cols    (cols),
    .pressed (pressed),
    .key     (key)
  );

  task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [3:0] c, input logic p, input logic [3:0] k);
    chk4({nm, ".cols"}, cols, c);
    chk1({nm, ".pressed"}, pressed, p);
    chk4({nm, ".key"}, key, k);
  endtask

  // Returns at the negedge right after the next tick edge (counter sampled == 4 mod 8).
  task automatic next_tick();
    int n;
    n = 0;
    @(negedge clk);
    while (counter[2:0] != 3'd4 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) begin
      total++;
      bad++;
      $display("FAIL tick_wait: got timeout expected tick");
    end
    @(negedge clk);
  endtask

  task automatic wait_phase0();
    int n;
    n = 0;
    while (counter[2:0] != 3'd0 && n < 16) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    keys_down = v.keys;
    exp_q.push_back(v);
    next_tick();
    e = exp_q.pop_front();
    chk_out(e.name, e.cols, e.pressed, e.key);
  endtask

  initial begin
    vec_t v;
    int   n;

    vecs.push_back('{16'h0000, 4'b1101, 1'b0, 4'h0, "scan1"});
    vecs.push_back('{16'h0000, 4'b1011, 1'b0, 4'h0, "scan2"});
    vecs.push_back('{16'h0000, 4'b0111, 1'b0, 4'h0, "scan3"});
    vecs.push_back('{16'h0000, 4'b1110, 1'b0, 4'h0, "scan_wrap"});
    vecs.push_back('{16'h0020, 4'b1101, 1'b0, 4'h0, "k5_wait"});
    vecs.push_back('{16'h0020, 4'b1101, 1'b1, 4'h5, "k5_det"});
    vecs.push_back('{16'h0020, 4'b1101, 1'b1, 4'h5, "k5_hold"});
    vecs.push_back('{16'h0000, 4'b1011, 1'b0, 4'h5, "k5_rel"});
    vecs.push_back('{16'h0808, 4'b0111, 1'b0, 4'h5, "multi_c2"});
    vecs.push_back('{16'h0808, 4'b1110, 1'b0, 4'h5, "multi_c3"});
    vecs.push_back('{16'h0808, 4'b1101, 1'b0, 4'h5, "multi_c0"});
    vecs.push_back('{16'h0808, 4'b1011, 1'b0, 4'h5, "multi_c1"});
    vecs.push_back('{16'h0808, 4'b0111, 1'b0, 4'h5, "multi_c2b"});
    vecs.push_back('{16'h0808, 4'b1110, 1'b0, 4'h5, "multi_c3b"});
    vecs.push_back('{16'h0000, 4'b1101, 1'b0, 4'h5, "idle_c0"});
    vecs.push_back('{16'h0000, 4'b1011, 1'b0, 4'h5, "idle_c1"});
    vecs.push_back('{16'h0000, 4'b0111, 1'b0, 4'h5, "idle_c2"});
    vecs.push_back('{16'h8000, 4'b0111, 1'b1, 4'hD, "kD_det"});
    vecs.push_back('{16'h8000, 4'b0111, 1'b1, 4'hD, "kD_hold"});
    vecs.push_back('{16'h0000, 4'b1110, 1'b0, 4'hD, "kD_rel"});
    vecs.push_back('{16'h0001, 4'b1110, 1'b1, 4'h1, "k1_det"});
    vecs.push_back('{16'h0101, 4'b1110, 1'b1, 4'h1, "k1_plus_r2"});
    vecs.push_back('{16'h0101, 4'b1110, 1'b1, 4'h1, "k1_plus_r2b"});
    vecs.push_back('{16'h0001, 4'b1110, 1'b1, 4'h1, "k1_hold"});

    // Reset for at least 3 cycles, released so the first free edge samples counter[2]=0.
    reset = 1'b1;
    keys_down = '0;
    repeat (3) @(negedge clk);
    wait_phase0();
    reset = 1'b0;
    chk_out("reset", 4'b1110, 1'b0, 4'h0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset mid-HOLD with key 1 still down.
    wait_phase0();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_out("rst_hold", 4'b1110, 1'b0, 4'h0);
    @(negedge clk);
    chk_out("rst_hold_quiet", 4'b1110, 1'b0, 4'h0);
    v = '{16'h0001, 4'b1110, 1'b1, 4'h1, "rst_redetect"};
    run_vec(v);
    v = '{16'h0000, 4'b1101, 1'b0, 4'h1, "rst_rel"};
    run_vec(v);

    // A short press entirely between ticks must not be seen.
    keys_down = 16'h0020;
    repeat (3) @(negedge clk);
    keys_down = '0;
    chk_out("glitch_between", 4'b1101, 1'b0, 4'h1);
    next_tick();
    chk_out("glitch", 4'b1011, 1'b0, 4'h1);

    // Every key position: detect within a bounded number of ticks, then release.
    for (int k = 0; k < 16; k++) begin
      keys_down = 16'(1) << k;
      n = 0;
      while (!pressed && n < 6) begin
        next_tick();
        n++;
      end
      chk1($sformatf("map%0d.pressed", k), pressed, 1'b1);
      chk4($sformatf("map%0d.key", k), key, legend[k]);
      chk4($sformatf("map%0d.cols", k), cols, ~(4'b0001 << (k % 4)));
      keys_down = '0;
      next_tick();
      chk1($sformatf("map%0d.rel", k), pressed, 1'b0);
      chk4($sformatf("map%0d.relkey", k), key, legend[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
